// File: rtl/aes_key_schedule_ctrl.sv
// Key schedule sequencer around a single, reused AES key expansion stage.
// Each round takes two cycles: ISSUE drives the stage, CAPTURE stores its
// registered result. Round keys 0..ROUNDS are kept in an internal bank and
// read back through a registered read port.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, key_in       request to expand key_in (honoured in IDLE/DONE only)
//   busy, keys_valid    expansion in progress / complete schedule in bank
//   xp_enable, xp_key,  drive to the expansion stage (enable, previous key,
//   xp_keynum           round number)
//   xp_key_out          registered next round key from the stage
//   rd_en, rd_idx       read request and round-key index
//   rd_valid, rd_key,   one-cycle read response, key and illegal-read flag
//   rd_err
module aes_key_schedule_ctrl #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0][3:0][3:0]  key_in,
  output logic                  busy,
  output logic                  keys_valid,
  output logic                  xp_enable,
  output logic [7:0][3:0][3:0]  xp_key,
  output logic [3:0]            xp_keynum,
  input  logic [7:0][3:0][3:0]  xp_key_out,
  input  logic                  rd_en,
  input  logic [3:0]            rd_idx,
  output logic                  rd_valid,
  output logic [7:0][3:0][3:0]  rd_key,
  output logic                  rd_err
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS);

  typedef logic [7:0][3:0][3:0] key_t;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] round;
  key_t             bank [0:ROUNDS];

  // Sequencer: state, stage drive, bank writes. xp_key doubles as the
  // current-key register; it only changes when entering ISSUE so it holds
  // its last value elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      xp_enable  <= 1'b0;
      xp_key     <= '0;
      xp_keynum  <= '0;
      round      <= '0;
      for (int unsigned i = 0; i <= ROUNDS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bank[0]    <= key_in;
            xp_key     <= key_in;
            xp_keynum  <= IDX_W'(1);
            xp_enable  <= 1'b1;
            round      <= IDX_W'(1);
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= ISSUE;
          end else begin
            // keys_valid follows DONE by one cycle
            keys_valid <= (state == DONE);
          end
        end
        ISSUE: begin
          xp_enable <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          bank[round] <= xp_key_out;
          if (round == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            round     <= round + IDX_W'(1);
            xp_key    <= xp_key_out;
            xp_keynum <= round + IDX_W'(1);
            xp_enable <= 1'b1;
            state     <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; a read racing a CAPTURE sees the old entry, but
  // keys_valid is low then so the response is an error regardless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if ((rd_idx > LAST) || !keys_valid) begin
          rd_err <= 1'b1;
          rd_key <= '0;
        end else begin
          rd_err <= 1'b0;
          rd_key <= bank[rd_idx];
        end
      end else begin
        rd_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequencer that sits around the single-round key expansion stage. It feeds the stage the previous round key and the round number, captures each registered result, and stores all round keys 0..ROUNDS in an internal bank. The cipher datapath then reads round keys through a registered read port with a handshake. One expansion stage is reused for every round, so each round takes two cycles: ISSUE, then CAPTURE.

Parameters:
ROUNDS, 10, number of expansion rounds; the bank holds ROUNDS+1 keys; legal range 1..10 (AES-128 uses 10)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to expand key_in; honoured only in IDLE or DONE
key_in  in  [7:0][3:0][3:0]  cipher key; byte [r][c] is key byte 4*c+r (column-major state layout)
busy  out  1  high while expansion is in progress
keys_valid  out  1  high when the bank holds a complete schedule
xp_enable  out  1  enable to the expansion stage
xp_key  out  [7:0][3:0][3:0]  previous round key to the expansion stage (its key_array)
xp_keynum  out  4  round number 1..ROUNDS to the expansion stage (its Rcon index)
xp_key_out  in  [7:0][3:0][3:0]  registered next round key from the expansion stage
rd_en  in  1  read request
rd_idx  in  4  round-key index 0..ROUNDS
rd_valid  out  1  one-cycle pulse; rd_key/rd_err are valid while it is high
rd_key  out  [7:0][3:0][3:0]  round key read from the bank
rd_err  out  1  set with rd_valid when the read is illegal

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, keys_valid, xp_enable, rd_valid, rd_err = 0; xp_key, xp_keynum, rd_key = 0; round counter = 0; all bank entries = 0.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE or DONE, start=1:
  - bank[0] <= key_in; cur <= key_in; round <= 1; keys_valid <= 0; go to ISSUE.
  - busy is 1 from the next cycle onward.
- ISSUE (one cycle):
  - xp_enable=1, xp_key=cur, xp_keynum=round.
  - The stage registers its result at the end of this cycle. Go to CAPTURE.
- CAPTURE (one cycle):
  - xp_enable=0.
  - bank[round] <= xp_key_out; cur <= xp_key_out.
  - If round==ROUNDS, go to DONE. Otherwise round <= round+1 and go to ISSUE.
- DONE: busy=0, keys_valid=1; stays until start or reset.
- Outside ISSUE: xp_enable=0; xp_key and xp_keynum hold their last values.
- Latency: start sampled at edge 0; CAPTURE of round n occurs at edge 2n; keys_valid rises after edge 2*ROUNDS+1 (edge 21 for ROUNDS=10).
- start during ISSUE or CAPTURE is ignored; no restart and no error.
- start in DONE restarts expansion and clears keys_valid immediately (next cycle).
- Read port: rd_en sampled at edge t gives rd_valid=1 in cycle t+1 with rd_key and rd_err. rd_valid is 0 when rd_en was 0.
- rd_err=1 and rd_key=0 when rd_idx>ROUNDS or keys_valid=0 at the sampling edge. Otherwise rd_key=bank[rd_idx] and rd_err=0.
- Back-to-back reads: one per cycle, no stall.
- Read and CAPTURE on the same edge: the read returns the old contents. This only arises with keys_valid=0, so that read reports rd_err anyway.
- rd_key holds its value when rd_valid=0.
- Reset mid-expansion aborts immediately. The bank is cleared; a later start runs a full fresh expansion.

Test Plan:
- Reset, then start with key 2b7e1516 28aed2a6 abf71588 09cf4f3c, real expansion stage attached -> busy for 20 cycles; keys_valid rises at edge 21; xp_keynum steps 1..10 on the ISSUE cycles only.
- After done, read idx 0, 1, 10 back-to-back -> rd_valid on 3 consecutive cycles with keys 2b7e1516…, a0fafe17 88542cb1 23a33939 2a6c7605, and d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rd_err=0.
- Read idx 11 and 15 after done, and idx 0 before any start -> rd_valid=1, rd_err=1, rd_key=0.
- start pulsed at cycles 5 and 9 during expansion -> ignored; completion still at edge 21 with correct keys.
- Assert reset at cycle 7, release, then start with an all-zero key -> keys_valid=0 and bank cleared immediately; round 10 key = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- start in DONE with a new key (all-zero) -> keys_valid drops the next cycle; reads during expansion give rd_err=1; final bank matches the new schedule.
